// File: rtl/instr_fetch.sv
//==============================================================================
// Module      : instr_fetch
// Description : Single-outstanding-request instruction fetch unit with a
//               one-entry hold register for the decoder and redirect support.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module instr_fetch #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               enable,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ready,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [2:0]         opcode,
    output logic [3:0]         func,
    output logic [ADDR_W-1:0]  pc_out,
    input  logic               instr_ack,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc
);

    localparam logic [ADDR_W-1:0] c_RESET_PC = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] c_PC_ONE   = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_capture;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc_out;

    // A redirect squashes any same-cycle transfer, so capture is gated by it.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        if (redirect) begin
            w_state_next = enable ? S_FETCH : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) w_state_next = S_FETCH;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        w_capture    = 1'b1;
                        w_state_next = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (instr_ack) w_state_next = enable ? S_FETCH : S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_pc     <= c_RESET_PC;
            r_instr  <= '0;
            r_pc_out <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_instr  <= mem_rdata;
                r_pc_out <= r_pc;
            end
            if (redirect) begin
                r_pc <= redirect_pc;
            end else if (w_capture) begin
                r_pc <= r_pc + c_PC_ONE;
            end
        end
    end

    assign mem_req     = (r_state == S_FETCH);
    assign mem_addr    = r_pc;
    assign instr_valid = (r_state == S_HOLD);
    assign instr       = r_instr;
    assign pc_out      = r_pc_out;
    assign opcode      = r_instr[15:13];
    assign func        = r_instr[3:0];

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning instruction address width in words.
REQ-002 SHALL have parameter INSTR_W, default 16, meaning instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-004 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  permits new fetches.
REQ-007 SHALL have port mem_req  output  1  instruction memory read request.
REQ-008 SHALL have port mem_addr  output  ADDR_W  read address, equals pc.
REQ-009 SHALL have port mem_ready  input  1  read data valid; transfer occurs on mem_req && mem_ready.
REQ-010 SHALL have port mem_rdata  input  INSTR_W  read data.
REQ-011 SHALL have port instr_valid  output  1  held instruction valid for the decoder.
REQ-012 SHALL have port instr  output  INSTR_W  held instruction word.
REQ-013 SHALL have port opcode  output  3  instr[15:13], the opcode field presented to the control decoder.
REQ-014 SHALL have port func  output  4  instr[3:0], the function field presented to the control decoder.
REQ-015 SHALL have port pc_out  output  ADDR_W  address of the held instruction.
REQ-016 SHALL have port instr_ack  input  1  decoder consumes instr when asserted with instr_valid.
REQ-017 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-018 SHALL have port redirect_pc  input  ADDR_W  redirect target.

Function
REQ-019 SHALL implement a three-state machine: IDLE, FETCH, HOLD.
REQ-020 IDLE: mem_req=0, instr_valid=0; enable=1 -> FETCH next cycle.
REQ-021 FETCH: mem_req=1, mem_addr=pc held stable until transfer; enable deassertion does not abandon a request.
REQ-022 FETCH with mem_ready=1: instr<=mem_rdata, pc_out<=pc, pc<=pc+1 modulo 2^ADDR_W, -> HOLD.
REQ-023 HOLD: instr_valid=1; instr, opcode, func and pc_out SHALL remain stable until acknowledged.
REQ-024 HOLD with instr_ack=1: -> FETCH if enable=1, else -> IDLE; instr_valid=0 next cycle.
REQ-025 Latency: transfer in cycle N -> instr_valid=1 in cycle N+1; ack in cycle M -> mem_req=1 in cycle M+1 when enabled.
REQ-026 instr_ack while instr_valid=0 SHALL be ignored.
REQ-027 redirect=1 (any state) SHALL set pc<=redirect_pc, clear instr_valid, and enter FETCH if enable=1, else IDLE.
REQ-028 redirect SHALL take priority over a same-cycle mem_ready (data discarded, pc not incremented) and over a same-cycle instr_ack.
REQ-029 pc at all-ones SHALL wrap to 0 after a transfer.
REQ-030 opcode and func SHALL be purely combinational slices of the instr register.

Reset
REQ-031 reset=1 SHALL override all inputs, including redirect.
REQ-032 On reset: state=IDLE, pc=RESET_PC, instr=0, pc_out=0, mem_req=0, instr_valid=0, opcode=0, func=0.
REQ-033 Reset asserted mid-fetch or in HOLD SHALL discard the outstanding request and the held instruction.

Verification
REQ-034 Reset, enable=1, mem_ready=1 always, mem_rdata=0x2001 at addr 0 -> mem_req in cycle 1, instr_valid cycle 2, opcode=1, func=1, pc_out=0; after ack, mem_addr=1.
REQ-035 mem_ready delayed 3 cycles -> mem_addr constant at pc for all 4 request cycles; one instruction captured; instr_valid the following cycle.
REQ-036 instr_ack held 0 for 5 cycles in HOLD -> instr, pc_out and instr_valid unchanged, mem_req=0 throughout.
REQ-037 redirect=1, redirect_pc=0x0040 in the same cycle as mem_ready -> data discarded, next mem_addr=0x0040, no instr_valid pulse from the discarded word.
REQ-038 pc=0xFFFF transfer -> pc_out=0xFFFF, next mem_addr=0x0000.
REQ-039 reset asserted in HOLD with redirect=1 -> next cycle IDLE, pc=RESET_PC, instr_valid=0.
